// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider for DIV, DIVU, REM and REMU.
// One quotient bit per clock; divide-by-zero and overflow finish in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       DivOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DivResult
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             sgn;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             unused_diff;

  assign unused_diff = diff[WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    accept = Start && (state_q == IDLE || state_q == DONE);
    sgn    = ~DivOp[0];
    b_zero = (B == '0);
    ovf    = sgn && (A == {1'b1, {(WIDTH-1){1'b0}}})
                 && (B == '1);
    a_abs  = (sgn && A[WIDTH-1]) ? -A : A;
    b_abs  = (sgn && B[WIDTH-1]) ? -B : B;

    // Partial remainder can reach WIDTH+1 bits after the shift
    sh     = {rem_q, quo_q[WIDTH-1]};
    diff   = {1'b0, sh} - {2'b00, dvs_q};
    borrow = diff[WIDTH+1];

    q_fix  = qneg_q ? -quo_q : quo_q;
    r_fix  = rneg_q ? -rem_q : rem_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d = DivOp;
          if (b_zero) begin
            res_d   = DivOp[1] ? A : '1;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = DivOp[1] ? '0 : A;
            state_d = DONE;
          end else begin
            quo_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_d  = sgn & A[WIDTH-1];
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = borrow ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1))
          state_d = FIX;
      end
      FIX: begin
        res_d   = op_q[1] ? r_fix : q_fix;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivResult = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit.
// Expected results and latencies are hand-computed constants.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  DivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] DivResult;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .DivOp     (DivOp),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .DivResult (DivResult)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1;
    DivOp = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    DivOp = 2'($urandom);
    A     = $urandom;
    B     = $urandom;
  endtask

  // Called 1 time unit after the accept edge
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!Done && lat < 100) begin
      if (Busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] exp,
                     input int exp_lat);
    int lat, busy_n;
    issue(op, a, b);
    wait_done(lat, busy_n);
    chk({tag, " res"}, DivResult, exp);
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy"}, 32'(busy_n), 32'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, busy_n, done_n;
    reset = 1'b1;
    Start = 1'b0;
    DivOp = 2'b00;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, Busy}, 32'd0);
    chk("rst done", {31'd0, Done}, 32'd0);
    chk("rst res", DivResult, 32'd0);
    reset = 1'b0;

    run("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("rem negb", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run("div -100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run("rem -100/7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run("divu big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);

    repeat (3) @(posedge clk);
    #1;
    chk("idle hold", DivResult, 32'h7FFF_FFFC);

    run("divu /0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run("remu /0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    run("div /0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
    run("rem /0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run("divu noovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // Start during RUN must be ignored
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    Start = 1'b1;
    DivOp = OP_DIV;
    A     = 32'd1000;
    B     = 32'd3;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_done(lat, busy_n);
    chk("ign res", DivResult, 32'd14);
    chk("ign lat", 32'(lat), 32'd23);

    // Back-to-back issue from the DONE cycle
    Start = 1'b1;
    DivOp = OP_REMU;
    A     = 32'd100;
    B     = 32'd7;
    @(posedge clk);
    #1;
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    chk("b2b busy", {31'd0, Busy}, 32'd1);
    chk("b2b hold", DivResult, 32'd14);
    wait_done(lat, busy_n);
    chk("b2b res", DivResult, 32'd2);
    chk("b2b lat", 32'(lat), 32'd33);

    // Asynchronous reset mid-RUN
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst busy", {31'd0, Busy}, 32'd0);
    chk("arst done", {31'd0, Done}, 32'd0);
    chk("arst res", DivResult, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) done_n++;
    end
    chk("arst nodone", 32'(done_n), 32'd0);
    run("post rst", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 RV32M divider. Executes DIV, DIVU, REM and REMU, which the single-cycle ALU does not implement.
- Sits beside the ALU in the execute stage. Control logic issues a request with Start and stalls the PC until Done.
- One quotient bit is produced per clock. Divide-by-zero and signed-overflow cases complete on a fast path.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  request strobe; accepted only when Busy=0.
- DivOp  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (equal to funct3[1:0]).
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- Busy  output  1  high while an operation is iterating.
- Done  output  1  one-cycle pulse; DivResult is valid from this cycle onward.
- DivResult  output  WIDTH  quotient or remainder, held until the next accepted Start.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, applied through the reset port.
- While reset is high:
  - state goes to IDLE;
  - Busy=0, Done=0, DivResult=0;
  - all internal registers are cleared.
- Reset mid-operation aborts the operation. No Done is produced for the aborted request.
- States:
  - IDLE: Busy=0, Done=0.
  - RUN: Busy=1.
  - FIX: Busy=1.
  - DONE: Busy=0, Done=1.
- Acceptance: a request is accepted at a rising edge with Start=1 while the state is IDLE or DONE. Back-to-back issue from DONE is allowed.
- Start while Busy=1 is ignored and has no side effects.
- At the accept edge, latch DivOp. Decide the path:
  - Fast path, B==0:
    - quotient = all ones;
    - remainder = A, for both signed and unsigned ops.
  - Fast path, signed op with A==0x8000_0000 (most-negative) and B==all ones (-1):
    - quotient = A;
    - remainder = 0.
  - For both fast paths, the accept edge registers the selected value into DivResult and the next state is DONE. Done is high in the cycle following the accept edge (latency 1).
  - Normal path:
    - latch |A| and |B| for signed ops, or A and B for unsigned ops;
    - record the quotient sign (sign(A) XOR sign(B)) and the remainder sign (sign(A));
    - clear the partial remainder and the iteration counter;
    - next state is RUN.
- RUN, one iteration per edge, WIDTH iterations:
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract the divisor from the partial remainder, using a WIDTH+1-bit subtract to catch the borrow;
  - if no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0;
  - the counter increments, and after iteration WIDTH the next state is FIX.
- FIX, one edge:
  - negate the quotient if its sign flag is set; negate the remainder if its sign flag is set;
  - register into DivResult the quotient for DIV/DIVU, or the remainder for REM/REMU;
  - next state is DONE.
- Normal-path latency: accept at edge E0, iterations at E1..E32, FIX result registered at E33. Done is high between E33 and E34, so Done appears 33 cycles after acceptance.
- DONE lasts one cycle. Next state is RUN or DONE if a new Start is accepted, otherwise IDLE. DivResult stays unchanged in IDLE.
- DivResult changes only at a FIX edge, a fast-path accept edge, or reset.
- A and B may change freely after the accept edge. Only latched copies are used.
- Arithmetic rules:
  - truncating division toward zero;
  - remainder sign equals dividend sign;
  - all results are taken modulo 2^WIDTH.

Test Plan:
- DIVU A=100, B=7, then REMU with the same operands → DivResult=14, then 2. Done pulses exactly 33 cycles after each accept, and Busy is high for 32+1 cycles.
- DIV A=-7 (0xFFFF_FFF9), B=2 → 0xFFFF_FFFD (-3). REM with the same operands → 0xFFFF_FFFF (-1). REM A=7, B=-2 → 1.
- DIVU A=5, B=0 → 0xFFFF_FFFF. REMU A=5, B=0 → 5. DIV A=-5, B=0 → 0xFFFF_FFFF. In each case Done is high in the cycle after accept and Busy never asserts.
- DIV A=0x8000_0000, B=0xFFFF_FFFF → 0x8000_0000. REM with the same operands → 0. Both take the 1-cycle fast path.
- Start pulsed with different operands at cycle 10 of a running DIVU 100/7 → the pulse is ignored and the result is still 14. A new Start asserted in the DONE cycle is accepted, and its Done follows 33 cycles later.
- reset asserted asynchronously mid-RUN → Busy, Done and DivResult go to 0 immediately and no Done follows. After release, DIVU 0xFFFF_FFFF / 1 → 0xFFFF_FFFF.
